// File: rtl/pe_pkg.sv
// Shared constants and types for the PE crossbar and its context sequencer.
package pe_pkg;

    localparam int SW_W    = 12;
    localparam int FIELD_W = 3;

    // Crossbar source selects; field values above SEL_LSU are illegal.
    localparam logic [FIELD_W-1:0] SEL_N   = 3'd0;
    localparam logic [FIELD_W-1:0] SEL_S   = 3'd1;
    localparam logic [FIELD_W-1:0] SEL_W   = 3'd2;
    localparam logic [FIELD_W-1:0] SEL_E   = 3'd3;
    localparam logic [FIELD_W-1:0] SEL_LSU = 3'd4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/pe_ctx_regfile.sv
// Context register file: one synchronous write port, one combinational read
// port, asynchronously cleared.
module pe_ctx_regfile #(
    parameter int CTX_DEPTH = 8,
    parameter int CTX_AW    = 3,
    parameter int SW_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CTX_AW-1:0] wr_addr,
    input  logic [SW_W-1:0]   wr_data,
    input  logic [CTX_AW-1:0] rd_addr,
    output logic [SW_W-1:0]   rd_data
);

    logic [SW_W-1:0] mem [CTX_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CTX_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_switch_ctx_loader.sv
// Context sequencer driving the PE crossbar switch word: loads sanitized
// contexts over a valid/ready port and replays them cyclically on command.
module pe_switch_ctx_loader #(
    parameter int CTX_DEPTH = 8,
    parameter int CTX_AW    = 3,
    parameter int SW_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CTX_AW-1:0] cfg_addr,
    input  logic [SW_W-1:0]   cfg_data,
    input  logic              cfg_last,
    input  logic              run_start,
    input  logic              run_stop,
    input  logic              run_stall,
    output logic [SW_W-1:0]   switch,
    output logic [CTX_AW-1:0] ctx_idx,
    output logic              busy,
    output logic              cfg_err
);

    import pe_pkg::*;

    state_t            state, next_state;
    logic [CTX_AW:0]   ctx_cnt;
    logic [CTX_AW-1:0] next_idx;
    logic [CTX_AW-1:0] rd_addr;
    logic [SW_W-1:0]   rd_data;
    logic [SW_W-1:0]   cfg_data_san;
    logic              field_bad;
    logic              wr_en;
    logic              do_load;
    logic              do_adv;
    logic              do_stop;

    // Illegal selects (5..7) are clamped to the LSU source.
    always_comb begin
        cfg_data_san = cfg_data;
        field_bad    = 1'b0;
        for (int f = 0; f < SW_W / FIELD_W; f++) begin
            if (cfg_data[f*FIELD_W +: FIELD_W] > SEL_LSU) begin
                cfg_data_san[f*FIELD_W +: FIELD_W] = SEL_LSU;
                field_bad = 1'b1;
            end
        end
    end

    assign wr_en    = cfg_valid && cfg_ready;
    assign next_idx = ({1'b0, ctx_idx} == ctx_cnt - 1'b1) ? '0 : ctx_idx + 1'b1;
    assign rd_addr  = (state == RUN) ? next_idx : '0;

    pe_ctx_regfile #(
        .CTX_DEPTH (CTX_DEPTH),
        .CTX_AW    (CTX_AW),
        .SW_W      (SW_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data_san),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        do_load    = 1'b0;
        do_adv     = 1'b0;
        do_stop    = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !run_start;
                if (run_start && ctx_cnt != '0) begin
                    next_state = RUN;
                    do_load    = 1'b1;
                end
            end
            RUN: begin
                // Stop beats both start and stall.
                if (run_stop) begin
                    next_state = IDLE;
                    do_stop    = 1'b1;
                end else if (!run_stall) begin
                    do_adv = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch  <= '0;
            ctx_idx <= '0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
            ctx_cnt <= '0;
        end else begin
            if (do_load) begin
                switch  <= rd_data;
                ctx_idx <= '0;
                busy    <= 1'b1;
            end else if (do_adv) begin
                switch  <= rd_data;
                ctx_idx <= next_idx;
            end else if (do_stop) begin
                switch  <= '0;
                ctx_idx <= '0;
                busy    <= 1'b0;
            end
            if (wr_en && field_bad) begin
                cfg_err <= 1'b1;
            end
            if (wr_en && cfg_last) begin
                ctx_cnt <= {1'b0, cfg_addr} + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_switch_ctx_loader.sv
// Directed scoreboard bench for pe_switch_ctx_loader.
module tb_pe_switch_ctx_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_last;
    logic        run_start;
    logic        run_stop;
    logic        run_stall;
    logic [11:0] switch_w;
    logic [2:0]  ctx_idx;
    logic        busy;
    logic        cfg_err;

    typedef struct packed {
        logic [11:0] sw;
        logic [2:0]  idx;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;

    pe_switch_ctx_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .run_start (run_start),
        .run_stop  (run_stop),
        .run_stall (run_stall),
        .switch    (switch_w),
        .ctx_idx   (ctx_idx),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s: scoreboard empty, observed 0x%0h expected entry", tag, switch_w);
        end else begin
            e = sb_q.pop_front();
            checkVal({tag, ".switch"}, 32'(switch_w), 32'(e.sw));
            checkVal({tag, ".ctx_idx"}, 32'(ctx_idx), 32'(e.idx));
            checkVal({tag, ".busy"}, 32'(busy), 32'(e.busy));
        end
    endtask

    // Drive one cycle of inputs, record the expected outputs after the edge, then compare.
    task automatic applyStimulus(input string tag,
                                 input logic v, input logic [2:0] a, input logic [11:0] d,
                                 input logic l, input logic st, input logic sp, input logic sl,
                                 input logic [11:0] e_sw, input logic [2:0] e_idx, input logic e_busy);
        cfg_valid = v;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = l;
        run_start = st;
        run_stop  = sp;
        run_stall = sl;
        sb_q.push_back('{sw: e_sw, idx: e_idx, busy: e_busy});
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
        run_start = 1'b0; run_stop = 1'b0; run_stall = 1'b0;

        // Reset state
        #12;
        checkVal("rst.switch", 32'(switch_w), 32'h0);
        checkVal("rst.ctx_idx", 32'(ctx_idx), 32'h0);
        checkVal("rst.busy", 32'(busy), 32'h0);
        checkVal("rst.cfg_err", 32'(cfg_err), 32'h0);
        checkVal("rst.cfg_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start with no contexts is ignored
        run_start = 1'b1;
        #1;
        checkVal("idle.ready_vs_start", 32'(cfg_ready), 32'h0);
        applyStimulus("empty_start", 0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("empty_after", 0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        checkVal("idle.ready", 32'(cfg_ready), 32'h1);

        // Load three contexts
        applyStimulus("wr0", 1, 3'd0, 12'h0A3, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("wr1", 1, 3'd1, 12'h8D1, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("wr2", 1, 3'd2, 12'h444, 1, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        checkVal("legal.cfg_err", 32'(cfg_err), 32'h0);

        // Replay with wrap
        applyStimulus("run0", 0, 0, 12'h000, 0, 1, 0, 0, 12'h0A3, 3'd0, 1'b1);
        checkVal("run.cfg_ready", 32'(cfg_ready), 32'h0);
        applyStimulus("run1", 0, 0, 12'h000, 0, 0, 0, 0, 12'h8D1, 3'd1, 1'b1);
        applyStimulus("run2", 0, 0, 12'h000, 0, 0, 0, 0, 12'h444, 3'd2, 1'b1);
        applyStimulus("run_wrap", 0, 0, 12'h000, 0, 0, 0, 0, 12'h0A3, 3'd0, 1'b1);
        applyStimulus("run1b", 0, 0, 12'h000, 0, 0, 0, 0, 12'h8D1, 3'd1, 1'b1);

        // Stall at ctx_idx 1 for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 0, 0, 12'h000, 0, 0, 0, 1, 12'h8D1, 3'd1, 1'b1);
        end
        applyStimulus("unstall", 0, 0, 12'h000, 0, 0, 0, 0, 12'h444, 3'd2, 1'b1);

        // Write attempt while running must not land
        applyStimulus("run_wr", 1, 3'd1, 12'h000, 1, 0, 0, 0, 12'h0A3, 3'd0, 1'b1);

        // Start and stop together: stop wins
        applyStimulus("stop_prio", 0, 0, 12'h000, 0, 1, 1, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("restart0", 0, 0, 12'h000, 0, 1, 0, 0, 12'h0A3, 3'd0, 1'b1);
        applyStimulus("restart1", 0, 0, 12'h000, 0, 0, 0, 0, 12'h8D1, 3'd1, 1'b1);
        applyStimulus("restart2", 0, 0, 12'h000, 0, 0, 0, 0, 12'h444, 3'd2, 1'b1);
        applyStimulus("stop_stall", 0, 0, 12'h000, 0, 0, 1, 1, 12'h000, 3'd0, 1'b0);

        // Illegal fields are clamped and flagged
        applyStimulus("wr_bad", 1, 3'd0, 12'hFFF, 1, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        checkVal("bad.cfg_err", 32'(cfg_err), 32'h1);
        applyStimulus("bad_run0", 0, 0, 12'h000, 0, 1, 0, 0, 12'h924, 3'd0, 1'b1);
        applyStimulus("bad_hold1", 0, 0, 12'h000, 0, 0, 0, 0, 12'h924, 3'd0, 1'b1);
        applyStimulus("bad_hold2", 0, 0, 12'h000, 0, 0, 0, 0, 12'h924, 3'd0, 1'b1);
        applyStimulus("bad_stop", 0, 0, 12'h000, 0, 0, 1, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("wr_good", 1, 3'd2, 12'h444, 1, 0, 0, 0, 12'h000, 3'd0, 1'b0);
        checkVal("sticky.cfg_err", 32'(cfg_err), 32'h1);

        // Reset in the middle of a run at ctx_idx 2
        applyStimulus("mid0", 0, 0, 12'h000, 0, 1, 0, 0, 12'h924, 3'd0, 1'b1);
        applyStimulus("mid1", 0, 0, 12'h000, 0, 0, 0, 0, 12'h8D1, 3'd1, 1'b1);
        applyStimulus("mid2", 0, 0, 12'h000, 0, 0, 0, 0, 12'h444, 3'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("arst.switch", 32'(switch_w), 32'h0);
        checkVal("arst.ctx_idx", 32'(ctx_idx), 32'h0);
        checkVal("arst.busy", 32'(busy), 32'h0);
        checkVal("arst.cfg_err", 32'(cfg_err), 32'h0);
        checkVal("arst.cfg_ready", 32'(cfg_ready), 32'h1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post_rst_start", 0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 3'd0, 1'b0);
        applyStimulus("post_rst_idle", 0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0);

        checkVal("sb.drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
